// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store control stage.
//   - Access size encodings (SZ_W / SZ_H / SZ_B). The load sign/zero extender
//     uses the same encodings. The value 2'b11 is not named and decodes as a word.
//   - FSM state encoding for lsu_ctrl.
//   - is_misaligned(): natural-alignment check used by the optional trap
//     (LSU_MISALIGN_TRAP_EN).
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Byte accesses are always aligned. Halfwords need addr[0]=0.
    // Words (and the 2'b11 alias) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage : lsu_pkg

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational lane steering for one memory access.
//   Ports:
//     size       in  2   access size (SZ_W / SZ_H / SZ_B; 2'b11 decodes as word)
//     addr_lo    in  2   byte offset inside the 32-bit word
//     wdata      in  32  right-aligned store data
//     rdata      in  32  raw word returned by the data cache
//     be         out 4   byte enables of the addressed lanes
//     wdata_lane out 32  store data replicated across all lanes
//     rdata_lane out 32  selected lane, right-aligned, upper bits zero
//   Halfword accesses look only at addr_lo[1]. Word accesses ignore addr_lo.
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_lane
);

    logic [31:0] rd_shift_b;
    logic [31:0] rd_shift_h;

    // Shift the response down by whole bytes or halfwords. The lane mask is
    // applied below.
    assign rd_shift_b = rdata >> {addr_lo, 3'b000};
    assign rd_shift_h = rdata >> {addr_lo[1], 4'b0000};

    // NOTE: every output gets a default at the top of the block, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_lane = rdata;
        case (size)
            SZ_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_lane = {24'h000000, rd_shift_b[7:0]};
            end
            SZ_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_lane = {16'h0000, rd_shift_h[15:0]};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_lane = rdata;
            end
        endcase
    end

endmodule : lsu_lane_align

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store control stage between execute and the data cache.
//   It takes one op from execute and issues a word-aligned request with byte
//   enables. For loads it waits for the response and right-aligns the
//   selected lane for the sign/zero extender. While an op is outstanding it
//   stalls the pipeline.
//
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     ex_valid        op present from execute
//     ex_we           1 = store, 0 = load
//     ex_size         00 word, 01 half, 10 byte, 11 treated as word
//     ex_sign         load is signed (passed through to the extender)
//     ex_addr         byte address
//     ex_wdata        right-aligned store data
//     lsu_stall       hold execute and earlier stages
//     dc_req_*        cache request (val/ack handshake, addr, we, be, wdata)
//     dc_rsp_val/data cache load response; ignored outside the RSP state
//     wb_val          one-cycle pulse, load result valid
//     wb_data         selected lane, right-aligned, unused upper bits zero
//     wb_size/wb_sign captured ex_size/ex_sign for the extender
//     misalign        one-cycle misalignment pulse
//
//   Build option LSU_MISALIGN_TRAP_EN:
//     defined   - a misaligned half or word issues no request. The FSM goes
//                 IDLE -> DONE and pulses misalign instead of wb_val.
//     undefined - misalign is tied 0. Unused low address bits are ignored.
// ----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_valid,
    input  logic        ex_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,

    output logic        dc_req_val,
    input  logic        dc_req_ack,
    output logic [31:0] dc_req_addr,
    output logic        dc_req_we,
    output logic [3:0]  dc_req_be,
    output logic [31:0] dc_req_wdata,

    input  logic        dc_rsp_val,
    input  logic [31:0] dc_rsp_data,

    output logic        wb_val,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_size,
    output logic        wb_sign,
    output logic        misalign
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;

    // Op captured when it is accepted in IDLE.
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] wb_data_q;
    logic        trap_q;
    logic        mis_det;

    logic [1:0]  la_size;
    logic [1:0]  la_addr_lo;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;

    logic        accept;

    assign accept = (state_q == ST_IDLE) && ex_valid;

    // One aligner serves both directions. In IDLE it sees the incoming op
    // (byte enables and store data are registered at acceptance). Afterwards
    // it sees the captured op (load lane extraction in RSP).
    assign la_size    = (state_q == ST_IDLE) ? ex_size       : size_q;
    assign la_addr_lo = (state_q == ST_IDLE) ? ex_addr[1:0]  : addr_q[1:0];

    lsu_lane_align u_lane_align (
        .size       (la_size),
        .addr_lo    (la_addr_lo),
        .wdata      (ex_wdata),
        .rdata      (dc_rsp_data),
        .be         (la_be),
        .wdata_lane (la_wdata),
        .rdata_lane (la_rdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_det = is_misaligned(ex_size, ex_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (accept) begin
            trap_q <= mis_det;
        end
    end
`else
    assign mis_det = 1'b0;
    assign trap_q  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    state_d = mis_det ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (dc_req_ack) begin
                    state_d = we_q ? ST_DONE : ST_RSP;
                end
            end
            ST_RSP: begin
                if (dc_rsp_val) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // ex_valid is deliberately ignored here. The next op is
                // taken in IDLE one cycle later.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dc_req_val = (state_q == ST_REQ);
        lsu_stall  = accept || (state_q == ST_REQ) || (state_q == ST_RSP);
        wb_val     = (state_q == ST_DONE) && !we_q && !trap_q;
        misalign   = (state_q == ST_DONE) && trap_q;
    end

    // ------------------------------------------------------------------
    // Op capture and load data capture
    // ------------------------------------------------------------------
    // NOTE: every register here has a defined reset value. The request and
    // writeback fields are visible outputs and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            size_q    <= SZ_W;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= ex_we;
                size_q  <= ex_size;
                sign_q  <= ex_sign;
                addr_q  <= ex_addr;
                be_q    <= la_be;
                wdata_q <= la_wdata;
            end
            if ((state_q == ST_RSP) && dc_rsp_val) begin
                wb_data_q <= la_rdata;
            end
        end
    end

    // Request fields come straight from registers. They stay stable for the
    // whole REQ state, however long the cache takes to ack.
    assign dc_req_addr  = {addr_q[31:2], 2'b00};
    assign dc_req_we    = we_q;
    assign dc_req_be    = be_q;
    assign dc_req_wdata = wdata_q;

    assign wb_data = wb_data_q;
    assign wb_size = size_q;
    assign wb_sign = sign_q;

endmodule : lsu_ctrl

// File: tb/tb_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl. A reference model describes each access
//   as a run of bytes inside the word: size in bytes and naturally aligned
//   start byte. From that run it derives byte enables, replicated store data
//   and the gathered load result.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_sign;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_stall;
    logic        dc_req_val;
    logic        dc_req_ack;
    logic [31:0] dc_req_addr;
    logic        dc_req_we;
    logic [3:0]  dc_req_be;
    logic [31:0] dc_req_wdata;
    logic        dc_rsp_val;
    logic [31:0] dc_rsp_data;
    logic        wb_val;
    logic [31:0] wb_data;
    logic [1:0]  wb_size;
    logic        wb_sign;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_we        (ex_we),
        .ex_size      (ex_size),
        .ex_sign      (ex_sign),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .lsu_stall    (lsu_stall),
        .dc_req_val   (dc_req_val),
        .dc_req_ack   (dc_req_ack),
        .dc_req_addr  (dc_req_addr),
        .dc_req_we    (dc_req_we),
        .dc_req_be    (dc_req_be),
        .dc_req_wdata (dc_req_wdata),
        .dc_rsp_val   (dc_rsp_val),
        .dc_rsp_data  (dc_rsp_data),
        .wb_val       (wb_val),
        .wb_data      (wb_data),
        .wb_size      (wb_size),
        .wb_sign      (wb_sign),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit. Every wait in the bench is bounded by a fixed number
    // of cycles, so this only fires if the simulation itself misbehaves.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'b10:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int start_byte(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = size_bytes(sz);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] r;
        int n, b;
        n = size_bytes(sz);
        b = start_byte(sz, a);
        for (int i = 0; i < 4; i++) r[i] = (i >= b) && (i < b + n);
        return r;
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = size_bytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] rsp);
        logic [31:0] r;
        int n, b;
        n = size_bytes(sz);
        b = start_byte(sz, a);
        r = '0;
        for (int j = 0; j < n; j++) r[8*j +: 8] = rsp[8*(b + j) +: 8];
        return r;
    endfunction

    function automatic bit model_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % size_bytes(sz)) != 0;
`else
        return (sz == 2'b11) && 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_op(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
        ex_valid = 1'b1;
        ex_we    = we;
        ex_size  = sz;
        ex_sign  = sg;
        ex_addr  = a;
        ex_wdata = wd;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_val"},   32'(dc_req_val),  32'd0);
        check({pfx, "_wb_val"},    32'(wb_val),      32'd0);
        check({pfx, "_misalign"},  32'(misalign),    32'd0);
        check({pfx, "_req_we"},    32'(dc_req_we),   32'd0);
        check({pfx, "_req_be"},    32'(dc_req_be),   32'd0);
        check({pfx, "_wb_data"},   wb_data,          32'd0);
        check({pfx, "_wb_size"},   32'(wb_size),     32'd0);
        check({pfx, "_req_addr"},  dc_req_addr,      32'd0);
        check({pfx, "_req_wdata"}, dc_req_wdata,     32'd0);
        check({pfx, "_wb_sign"},   32'(wb_sign),     32'd0);
    endtask

    // Runs one op. On entry the DUT is in IDLE or DONE. With b2b set the
    // entry cycle is the DONE of the previous op: the op is presented there,
    // must be ignored, and is then accepted in the following IDLE cycle.
    // On return the DUT sits in the DONE cycle of this op.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_dly, input int rsp_dly,
                         input logic [31:0] rsp, input bit b2b);
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        bit          trap;
        e_be = model_be(sz, a);
        e_wd = model_store(sz, wd);
        e_ld = model_load(sz, a, rsp);
        trap = model_trap(sz, a);

        if (b2b) begin
            drive_op(we, sz, sg, a, wd);
            #1;
            check("b2b_done_stall", 32'(lsu_stall), 32'd0);
        end
        @(negedge clk);
        drive_op(we, sz, sg, a, wd);
        #1;
        check("acc_stall",   32'(lsu_stall),  32'd1);
        check("acc_req_val", 32'(dc_req_val), 32'd0);

        @(negedge clk);
        // Scramble execute inputs: the DUT must work from its captured copy.
        ex_valid = 1'b0;
        ex_we    = 1'($urandom);
        ex_size  = 2'($urandom);
        ex_sign  = 1'($urandom);
        ex_addr  = $urandom;
        ex_wdata = $urandom;

        if (trap) begin
            #1;
            check("trap_misalign", 32'(misalign),   32'd1);
            check("trap_req_val",  32'(dc_req_val), 32'd0);
            check("trap_wb_val",   32'(wb_val),     32'd0);
            check("trap_stall",    32'(lsu_stall),  32'd0);
            return;
        end

        for (int k = 0; k <= ack_dly; k++) begin
            if (k > 0) @(negedge clk);
            // Stray responses before the request is acked must be ignored.
            dc_rsp_val  = 1'($urandom);
            dc_rsp_data = $urandom;
            dc_req_ack  = (k == ack_dly);
            #1;
            check("req_val",   32'(dc_req_val), 32'd1);
            check("req_addr",  dc_req_addr,     {a[31:2], 2'b00});
            check("req_we",    32'(dc_req_we),  32'(we));
            check("req_be",    32'(dc_req_be),  32'(e_be));
            if (we) check("req_wdata", dc_req_wdata, e_wd);
            check("req_stall", 32'(lsu_stall),  32'd1);
            check("req_wb_val", 32'(wb_val),    32'd0);
        end
        @(negedge clk);
        dc_req_ack = 1'b0;
        dc_rsp_val = 1'b0;

        if (!we) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                if (k > 0) @(negedge clk);
                dc_rsp_val  = (k == rsp_dly);
                dc_rsp_data = (k == rsp_dly) ? rsp : $urandom;
                #1;
                check("rsp_req_val", 32'(dc_req_val), 32'd0);
                check("rsp_stall",   32'(lsu_stall),  32'd1);
                check("rsp_wb_val",  32'(wb_val),     32'd0);
            end
            @(negedge clk);
            dc_rsp_val  = 1'b0;
            dc_rsp_data = $urandom;
        end

        #1;
        check("done_wb_val",   32'(wb_val),     32'(!we));
        check("done_stall",    32'(lsu_stall),  32'd0);
        check("done_req_val",  32'(dc_req_val), 32'd0);
        check("done_misalign", 32'(misalign),   32'd0);
        if (!we) begin
            check("wb_data", wb_data,         e_ld);
            check("wb_size", 32'(wb_size),    32'(sz));
            check("wb_sign", 32'(wb_sign),    32'(sg));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_we       = 1'b0;
        ex_size     = 2'b00;
        ex_sign     = 1'b0;
        ex_addr     = '0;
        ex_wdata    = '0;
        dc_req_ack  = 1'b0;
        dc_rsp_val  = 1'b0;
        dc_rsp_data = '0;
        #1;
        check_reset_vals("rst");
        check("rst_stall", 32'(lsu_stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Byte load at 0x1003, immediate ack/rsp -> 0x000000AA in the top lane.
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'hAABB_CCDD, 1'b0);
        check("tp1_wb_data", wb_data, 32'h0000_00AA);
        // Half store at 0x2002 -> replicated 0x12341234, upper two lanes.
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_1234, 0, 0, 32'h0, 1'b0);
        // Word load with slow ack and slow response.
        do_op(1'b0, 2'b00, 1'b1, 32'h8000_0010, 32'h0, 3, 2, 32'hDEAD_BEEF, 1'b0);
        // Half load at odd address 0x11: trap with the option, else lanes 0-1.
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0, 0, 0, 32'h5566_7788, 1'b0);
        // Back-to-back loads.
        do_op(1'b0, 2'b10, 1'b1, 32'h0000_0042, 32'h0, 1, 0, 32'h0102_0304, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_0046, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b1);

        // Randomised ops, including 2'b11 sizes and back-to-back chaining.
        for (int i = 0; i < 200; i++) begin
            do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom, 1'($urandom));
        end

        // Reset while a load waits for its response. The late response is dropped.
        @(negedge clk);
        drive_op(1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0);
        @(negedge clk);
        ex_valid   = 1'b0;
        dc_req_ack = 1'b1;
        @(negedge clk);
        dc_req_ack = 1'b0;
        #1;
        check("mid_rsp_stall", 32'(lsu_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_stall", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        dc_rsp_val  = 1'b1;
        dc_rsp_data = 32'h1234_5678;
        #1;
        check("late_rsp_wb_val", 32'(wb_val), 32'd0);
        @(negedge clk);
        dc_rsp_val = 1'b0;
        #1;
        check("late_rsp_wb_val2", 32'(wb_val),     32'd0);
        check("late_rsp_req_val", 32'(dc_req_val), 32'd0);
        check("late_rsp_wb_data", wb_data,         32'd0);
        check("late_rsp_stall",   32'(lsu_stall),  32'd0);

        // The stage must be fully usable again after the reset.
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'h0, 0, 0, 32'h1122_3344, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lsu_ctrl
